micro_interval_timer: RTL and testbench

//   Consumes the free-running microsecond count timeMicro from microSeconds and times intervals
//   for the blackjack controller: deal delays, LED blink periods, player-input timeouts.
//   A start request latches a timestamp and a duration. The block pulses expired when the

---
 rtl/micro_interval_timer.sv | 61 ++++++
 tb/tb_micro_interval_timer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/micro_interval_timer.sv
// micro_interval_timer: one-shot/periodic interval timer on a free-running microsecond count, wrap-safe
module micro_interval_timer #(
  parameter int TW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] timeMicro,
  input  logic          start,
  input  logic          abort,
  input  logic          periodic,
  input  logic [DW-1:0] duration_us,
  output logic          busy,
  output logic          expired,
  output logic [TW-1:0] elapsed_us,
  output logic [CW-1:0] expire_count
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [TW-1:0] t0, dur, delta;
  logic per, hit;
  assign delta = timeMicro - t0;
  assign hit = delta >= dur;
  assign busy = state == RUN;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? RUN : IDLE;
    else if (abort) state_nx = IDLE;
    else if (!start && hit && !per) state_nx = IDLE;
  end
  // start in either state reloads the interval; abort only matters while running
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      t0 <= '0;
      dur <= '0;
      per <= 1'b0;
      expired <= 1'b0;
      elapsed_us <= '0;
      expire_count <= '0;
    end else begin
      expired <= 1'b0;
      if (start && (state == IDLE || !abort)) begin
        t0 <= timeMicro;
        dur <= TW'(duration_us);
        per <= periodic && duration_us != '0;
        elapsed_us <= '0;
        expire_count <= '0;
      end else if (state == RUN && !abort) begin
        elapsed_us <= delta;
        if (hit) begin
          expired <= 1'b1;
          expire_count <= expire_count + CW'(1);
          if (per) t0 <= t0 + dur;
        end
      end
    end
endmodule

// File: tb/tb_micro_interval_timer.sv
// tb_micro_interval_timer: directed vectors with an expiry scoreboard checked by a separate monitor
module tb_micro_interval_timer;
  logic clk = 0, rst = 0, start = 0, abort = 0, periodic = 0;
  logic [31:0] timeMicro = 0, duration_us = 0;
  logic busy, expired;
  logic [31:0] elapsed_us;
  logic [15:0] expire_count;
  int nchk = 0, nfail = 0;
  typedef struct {logic [15:0] cnt; logic [31:0] el; logic bz;} exp_t;
  exp_t q[$];

  micro_interval_timer dut (
    .clk(clk), .rst(rst), .timeMicro(timeMicro), .start(start), .abort(abort),
    .periodic(periodic), .duration_us(duration_us), .busy(busy), .expired(expired),
    .elapsed_us(elapsed_us), .expire_count(expire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] t, input logic s = 0, input logic a = 0,
                     input logic p = 0, input logic [31:0] d = 0);
    timeMicro = t; start = s; abort = a; periodic = p; duration_us = d;
    @(posedge clk);
    #1;
    start = 0; abort = 0;
  endtask

  task automatic expect_pulse(input logic [15:0] c, input logic [31:0] e, input logic b);
    exp_t x;
    x.cnt = c; x.el = e; x.bz = b;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst && expired) begin
      if (q.size() == 0) chk("unexpected_pulse", 32'(expire_count), 32'hFFFF_FFFF);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("pulse_count", 32'(expire_count), 32'(x.cnt));
        chk("pulse_elapsed", elapsed_us, x.el);
        chk("pulse_busy", 32'(busy), 32'(x.bz));
      end
    end
  end

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_expired", 32'(expired), 0);
    chk("rst_elapsed", elapsed_us, 0);
    chk("rst_count", 32'(expire_count), 0);
    #10 rst = 1;
    // one-shot
    cyc(1000, 1, 0, 0, 100);
    chk("os_busy", 32'(busy), 1);
    cyc(1050); cyc(1099);
    expect_pulse(1, 100, 0);
    cyc(1100); cyc(1101);
    chk("os_idle", 32'(busy), 0);
    chk("os_count", 32'(expire_count), 1);
    chk("os_elapsed", elapsed_us, 100);
    // wrap
    cyc(32'hFFFF_FFF0, 1, 0, 0, 20);
    cyc(32'hFFFF_FFFF); cyc(0); cyc(3);
    chk("wrap_early", 32'(busy), 1);
    expect_pulse(1, 20, 0);
    cyc(4); cyc(5);
    // periodic
    cyc(0, 1, 0, 1, 50);
    for (int t = 10; t <= 260; t += 10) begin
      if (t % 50 == 0) expect_pulse(16'(t / 50), 50, 1);
      cyc(t);
    end
    chk("per_count", 32'(expire_count), 5);
    chk("per_busy", 32'(busy), 1);
    cyc(270, 0, 1);
    chk("per_abort_busy", 32'(busy), 0);
    chk("per_abort_count", 32'(expire_count), 5);
    // abort on the expiring edge
    cyc(0, 1, 0, 0, 10);
    cyc(5);
    cyc(10, 0, 1);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_count", 32'(expire_count), 0);
    chk("ab_elapsed", elapsed_us, 5);
    cyc(20);
    // restart
    cyc(0, 1, 0, 0, 100);
    cyc(20); cyc(40); cyc(60);
    cyc(80, 1, 0, 0, 30);
    chk("rs_elapsed", elapsed_us, 0);
    cyc(100);
    chk("rs_no_pulse_100", 32'(busy), 1);
    expect_pulse(1, 30, 0);
    cyc(110); cyc(120);
    // periodic catch-up after a time jump
    cyc(0, 1, 0, 1, 5);
    expect_pulse(1, 12, 1);
    cyc(12);
    expect_pulse(2, 7, 1);
    cyc(12); cyc(12);
    chk("cu_count", 32'(expire_count), 2);
    cyc(13, 0, 1);
    // zero duration, periodic request ignored
    cyc(500, 1, 0, 1, 0);
    expect_pulse(1, 1, 0);
    cyc(501); cyc(502); cyc(503);
    chk("zero_idle", 32'(busy), 0);
    chk("zero_count", 32'(expire_count), 1);
    // async reset mid-run
    cyc(600, 1, 0, 0, 1000);
    cyc(610);
    chk("pre_rst_elapsed", elapsed_us, 10);
    #2 rst = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_expired", 32'(expired), 0);
    chk("arst_elapsed", elapsed_us, 0);
    chk("arst_count", 32'(expire_count), 0);
    #1 rst = 1;
    cyc(2000); cyc(3000);
    chk("post_rst_busy", 32'(busy), 0);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
